// File: rtl/rr_packet_scheduler.sv
// rtl/rr_packet_scheduler.sv - packet-level round-robin scheduler onto one registered output stream
module rr_packet_scheduler #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SRC_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] in_valid,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0] in_last,
    output logic [NUM_INPUTS-1:0] in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [SRC_W-1:0]      out_src,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam logic [NUM_INPUTS-1:0] ONE = NUM_INPUTS'(1);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [NUM_INPUTS-1:0]   grant_q, grant_d;
    logic [NUM_INPUTS-1:0]   base_q, base_d;
    logic [NUM_INPUTS-1:0]   masked_req, arb_grant, grant_rot;
    logic [SRC_W-1:0]        grant_idx;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;
    logic                    beat_xfer;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_last_q;
    logic [SRC_W-1:0]        out_src_q;

    // Requests at or above base win first; otherwise wrap to the lowest requester.
    always_comb begin
        masked_req = in_valid & ~(base_q - ONE);
        if (masked_req != '0) begin
            arb_grant = masked_req & (~masked_req + ONE);
        end else begin
            arb_grant = in_valid & (~in_valid + ONE);
        end
    end

    generate
        if (NUM_INPUTS == 1) begin : g_rot_single
            assign grant_rot = grant_q;
        end else begin : g_rot_multi
            assign grant_rot = {grant_q[NUM_INPUTS-2:0], grant_q[NUM_INPUTS-1]};
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_q[i]) begin
                grant_idx = SRC_W'(i);
                sel_data  = in_data[i];
                sel_last  = in_last[i];
            end
        end
    end

    assign beat_xfer = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid != '0) state_d = S_LOCKED;
            S_LOCKED: if (beat_xfer && sel_last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = '0;
        busy     = 1'b0;
        if (state_q == S_LOCKED) begin
            in_ready = grant_q & {NUM_INPUTS{!out_valid_q || out_ready}};
            busy     = 1'b1;
        end
    end

    always_comb begin
        grant_d = grant_q;
        base_d  = base_q;
        if (state_q == S_IDLE && in_valid != '0) begin
            grant_d = arb_grant;
        end
        if (state_q == S_LOCKED && beat_xfer && sel_last) begin
            base_d  = grant_rot;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            base_q  <= ONE;
        end else begin
            grant_q <= grant_d;
            base_q  <= base_d;
        end
    end

    // A load in the same cycle as a drain keeps out_valid asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (beat_xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
            out_src_q   <= grant_idx;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/rr_packet_scheduler.md
# rr_packet_scheduler

Packet-level round-robin scheduler that shares one output stream among `NUM_INPUTS` valid/ready requesters. Arbitration is rotating-priority. Once a requester is granted, the grant is held until that requester's `last` beat is accepted, so packets are never interleaved. The block sits in front of any shared single-port datapath consumer (serializer, memory write port, link) and registers its output.

## Interface
- `NUM_INPUTS`, 4, number of requesters; legal range 1..16.
- `DATA_WIDTH`, 8, payload width in bits.
- `SRC_W`, derived as max(1, $clog2(NUM_INPUTS)), width of the source index; not overridden.

Ports, clock and reset first:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  NUM_INPUTS  per-requester beat valid.
- `in_data`  in  DATA_WIDTH x NUM_INPUTS (unpacked)  per-requester payload.
- `in_last`  in  NUM_INPUTS  marks the final beat of a packet.
- `in_ready`  out  NUM_INPUTS  per-requester accept; one-hot or zero.
- `out_valid`  out  1  registered output beat valid.
- `out_data`  out  DATA_WIDTH  registered payload.
- `out_last`  out  1  registered last flag.
- `out_src`  out  SRC_W  index of the requester that produced the current output beat.
- `out_ready`  in  1  downstream accept.
- `busy`  out  1  high while in LOCKED.

## Operation
- **State machine.** Two states: IDLE and LOCKED.
- **IDLE.**
  - All `in_ready` are 0.
  - If `in_valid` != 0, compute a one-hot `grant` from `in_valid` and the priority pointer `base`: the first set bit at or above `base`, wrapping modulo NUM_INPUTS.
  - Register `grant` and go to LOCKED.
  - If `in_valid` == 0, stay in IDLE.
- **LOCKED.**
  - Only the granted requester sees ready: `in_ready[g] = !out_valid || out_ready`. Every other bit is 0.
  - A beat transfers on `in_valid[g] && in_ready[g]`. The beat loads `out_data`, `out_last` and `out_src = g`, and sets `out_valid`.
  - If the transferred beat has `in_last[g]=1`:
    - go to IDLE;
    - set `base` to `grant` rotated left by 1, so the requester after g gets highest priority;
    - clear `grant`.
- **Output register.**
  - `out_valid` clears on `out_ready` when no new beat is loaded in the same cycle.
  - If a beat drains and a new beat loads in the same cycle, `out_valid` stays 1.
- **Held grant.** The grant is held regardless of `in_valid[g]` dropping mid-packet. There is no timeout, and other requesters wait.
- **Priority pointer.**
  - `base` is a one-hot register, NUM_INPUTS wide.
  - Wrap: with g = NUM_INPUTS-1, `base` becomes bit 0.
  - With NUM_INPUTS=1, `base` stays 1'b1 and `out_src` stays 0.
- **Late requests.** `in_valid` of non-granted requesters is sampled only in IDLE. Requests raised during LOCKED compete at the next IDLE cycle.
- **Reset behaviour.**
  - `rst` in any state forces IDLE.
  - `base` = 1 (requester 0 highest priority), `grant` = 0.
  - Outputs: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, `busy`=0.
  - A packet in flight is dropped. The upstream must restart it.

## Timing
- **Arbitration.** One cycle. With `in_valid[i]` first high at cycle T in IDLE, `in_ready[i]` is high at T+1 (given an empty or draining output), and `out_valid` with the first beat is high at T+2.
- **Throughput.** One beat per cycle within a packet while `out_ready` stays 1.
- **Packet gap.** Exactly one bubble cycle on the input side between packets: the IDLE arbitration cycle. The output sees one cycle with `out_valid`=0 between packets when `out_ready` is held 1.
- **Backpressure.** `out_ready`=0 while `out_valid`=1 forces `in_ready`=0 in the same cycle (combinational from `out_valid`/`out_ready`). `out_data`, `out_last` and `out_src` hold stable.
- **Single-beat packet.** `in_last`=1 on the first beat: LOCKED lasts one cycle.
- **Combinational paths.** `out_ready` to `in_ready` is the only one.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with all inputs active. Require `in_ready`=0, `out_valid`=0, `out_src`=0 and `busy`=0 throughout. Require the first grant after release to go to input 0.
- **Rotation.** NUM_INPUTS=4, all four requesters continuously offer 1-beat packets with data = 0x10·i, `out_ready`=1. Require `out_src` sequence 0,1,2,3,0,… and `out_data` 0x00,0x10,0x20,0x30, each separated by one idle output cycle.
- **No interleave.**
  - Input 1 sends 3 beats (0xA1,0xA2,0xA3 last). Input 2 raises valid on the second beat.
  - Require output 0xA1,0xA2,0xA3 with `out_src`=1, then input 2's packet.
  - Require `in_ready[2]`=0 throughout input 1's packet.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles mid-packet. Require `out_data` stable, `in_ready`=0, and no beat lost or duplicated after release.
- **Wrap and skip.** With `base` at input 3, only inputs 1 and 3 request. Require order 3, then 1, then 3.
- **Reset mid-packet.** Assert `rst` during beat 2 of a 4-beat packet from input 2. Require immediate return to reset values. Require the next grant to go to the lowest-index requester.
